// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: shares the single GPR write port between the in-order WB stage (P)
// and the multi-cycle unit (M), keeping a busy scoreboard so outstanding M results
// cannot be overtaken by P writes or by new M issues to the same register.
module gpr_wb_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned NREG         = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    localparam int unsigned RW          = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            p_valid,
    output logic            p_ready,
    input  logic [RW-1:0]   p_rd,
    input  logic [XLEN-1:0] p_data,
    input  logic            m_valid,
    output logic            m_ready,
    input  logic [RW-1:0]   m_rd,
    input  logic [XLEN-1:0] m_data,
    input  logic            iss_valid,
    output logic            iss_ready,
    input  logic [RW-1:0]   iss_rd,
    output logic            rf_wen,
    output logic [RW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [NREG-1:0] busy,
    output logic            sb_err
);

    localparam int unsigned WCW = $clog2(STARVE_LIMIT + 1);

    logic [WCW-1:0]  wait_cnt;
    logic            force_m;

    logic            p_blk;
    logic            p_xfer;
    logic            m_xfer;
    logic            iss_xfer;
    logic [WCW-1:0]  wait_cnt_d;
    logic            force_m_d;
    logic [NREG-1:0] busy_d;
    logic            sb_err_d;
    logic            wr_en_d;
    logic [RW-1:0]   wr_addr_d;
    logic [XLEN-1:0] wr_data_d;

    // Grant, starvation, scoreboard and write-port next-state decode
    always_comb begin
        p_blk      = 1'b0;
        p_ready    = 1'b0;
        m_ready    = 1'b0;
        iss_ready  = 1'b0;
        p_xfer     = 1'b0;
        m_xfer     = 1'b0;
        iss_xfer   = 1'b0;
        wait_cnt_d = '0;
        force_m_d  = 1'b0;
        busy_d     = busy;
        sb_err_d   = sb_err;
        wr_en_d    = 1'b0;
        wr_addr_d  = rf_waddr;
        wr_data_d  = rf_wdata;

        // P is held off while its destination still awaits an M result
        p_blk     = p_valid && (p_rd != '0) && busy[p_rd];
        p_ready   = !force_m && !p_blk;
        m_ready   = force_m || !p_valid || p_blk;
        iss_ready = !busy[iss_rd] || (iss_rd == '0);

        p_xfer   = p_valid && p_ready;
        m_xfer   = m_valid && m_ready;
        iss_xfer = iss_valid && iss_ready;

        // Count consecutive cycles M is refused; saturate at the limit
        if (m_valid && !m_ready) begin
            if (wait_cnt != WCW'(STARVE_LIMIT)) begin
                wait_cnt_d = wait_cnt + WCW'(1);
            end else begin
                wait_cnt_d = wait_cnt;
            end
        end
        force_m_d = (wait_cnt_d == WCW'(STARVE_LIMIT));

        // P and M grants are mutually exclusive, so one write source at most
        if (p_xfer) begin
            wr_en_d   = (p_rd != '0);
            wr_addr_d = p_rd;
            wr_data_d = p_data;
        end else if (m_xfer) begin
            wr_en_d   = (m_rd != '0);
            wr_addr_d = m_rd;
            wr_data_d = m_data;
            if ((m_rd != '0) && !busy[m_rd]) begin
                sb_err_d = 1'b1;
            end
            busy_d[m_rd] = 1'b0;
        end

        // iss_ready excludes busy registers, so a set never collides with a live clear
        if (iss_xfer && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            force_m  <= 1'b0;
            busy     <= '0;
            sb_err   <= 1'b0;
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            wait_cnt <= wait_cnt_d;
            force_m  <= force_m_d;
            busy     <= busy_d;
            sb_err   <= sb_err_d;
            rf_wen   <= wr_en_d;
            rf_waddr <= wr_addr_d;
            rf_wdata <= wr_data_d;
        end
    end

endmodule
